// File: rtl/tq_ram_rd_scan.sv
// tq_ram_rd_scan: read-side drainer for the 128x32 TQ coefficient RAM.
// Fetches one 4x4 block (two RAM rows) at a time, then streams its 16
// coefficients in zig-zag order over a valid/ready handshake to CAVLC.
// Optional build macro: TQ_RD_NZC_EN adds a per-block non-zero count on nzc_o;
// without it nzc_o is tied to zero.
module tq_ram_rd_scan #(
  parameter int unsigned COEF_W = 16,
  parameter int unsigned AW     = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [3:0]          blk_base_i,
  input  logic [4:0]          blk_cnt_i,
  output logic                rd,
  output logic [AW-1:0]       raddr,
  input  logic [8*COEF_W-1:0] rdata,
  output logic [COEF_W-1:0]   coef_o,
  output logic                coef_valid_o,
  input  logic                coef_ready_i,
  output logic                coef_last_o,
  output logic [3:0]          blk_idx_o,
  output logic [4:0]          nzc_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned ROW_W = 8 * COEF_W;
  localparam int unsigned BLK_W = 2 * ROW_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Zig-zag position -> raster coefficient index within the 4x4 block.
  function automatic logic [3:0] zz_map(input logic [3:0] p);
    logic [3:0] r;
    case (p)
      4'd0:    r = 4'd0;
      4'd1:    r = 4'd1;
      4'd2:    r = 4'd4;
      4'd3:    r = 4'd8;
      4'd4:    r = 4'd5;
      4'd5:    r = 4'd2;
      4'd6:    r = 4'd3;
      4'd7:    r = 4'd6;
      4'd8:    r = 4'd9;
      4'd9:    r = 4'd12;
      4'd10:   r = 4'd13;
      4'd11:   r = 4'd10;
      4'd12:   r = 4'd7;
      4'd13:   r = 4'd11;
      4'd14:   r = 4'd14;
      default: r = 4'd15;
    endcase
    return r;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_pos;
  logic [3:0]         w_pos_nxt;
  logic [3:0]         r_cur_blk;
  logic [3:0]         w_blk_nxt;
  logic [4:0]         r_rem;
  logic [4:0]         w_rem_nxt;
  logic [BLK_W-1:0]   r_buf;
  logic [BLK_W-1:0]   w_blk_src;
  logic [3:0]         w_zz;

  logic               r_rd;
  logic [AW-1:0]      r_raddr;
  logic [COEF_W-1:0]  r_coef;
  logic               r_coef_valid;
  logic               r_coef_last;
  logic [3:0]         r_blk_idx;
  logic               r_busy;
  logic               r_done;

  logic               w_rd_nxt;
  logic [AW-1:0]      w_raddr_nxt;
  logic [COEF_W-1:0]  w_coef_nxt;
  logic               w_valid_nxt;
  logic               w_last_nxt;
  logic [3:0]         w_blk_idx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and scan-counter update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_blk_nxt   = r_cur_blk;
    w_rem_nxt   = r_rem;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (blk_cnt_i != 5'd0) begin
            w_state_nxt = S_RD0;
            w_blk_nxt   = blk_base_i;
            w_rem_nxt   = blk_cnt_i - 5'd1;
            w_pos_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RD0: w_state_nxt = S_RD1;
      S_RD1: w_state_nxt = S_CAP;
      S_CAP: begin
        w_state_nxt = S_OUT;
        w_pos_nxt   = 4'd0;
      end
      S_OUT: begin
        if (r_coef_valid && coef_ready_i) begin
          w_pos_nxt = r_pos + 4'd1;
          if (r_pos == 4'd15) begin
            w_pos_nxt = 4'd0;
            if (r_rem != 5'd0) begin
              w_state_nxt = S_RD0;
              w_blk_nxt   = r_cur_blk + 4'd1;
              w_rem_nxt   = r_rem - 5'd1;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In CAP the upper row is still on rdata, so the block is assembled on the fly.
  assign w_blk_src = (r_state == S_CAP) ? {rdata, r_buf[ROW_W-1:0]} : r_buf;
  assign w_zz      = zz_map(w_pos_nxt);

  // Output decode from the next state, so every port leaves a flop.
  always_comb begin
    w_rd_nxt      = 1'b0;
    w_raddr_nxt   = '0;
    w_coef_nxt    = '0;
    w_valid_nxt   = 1'b0;
    w_last_nxt    = 1'b0;
    w_blk_idx_nxt = '0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      S_RD0: begin
        w_rd_nxt    = 1'b1;
        w_raddr_nxt = AW'({w_blk_nxt, 1'b0});
        w_busy_nxt  = 1'b1;
      end
      S_RD1: begin
        w_rd_nxt    = 1'b1;
        w_raddr_nxt = AW'({w_blk_nxt, 1'b1});
        w_busy_nxt  = 1'b1;
      end
      S_CAP: w_busy_nxt = 1'b1;
      S_OUT: begin
        w_busy_nxt    = 1'b1;
        w_valid_nxt   = 1'b1;
        w_coef_nxt    = w_blk_src[w_zz*COEF_W +: COEF_W];
        w_last_nxt    = (w_pos_nxt == 4'd15);
        w_blk_idx_nxt = w_blk_nxt;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos     <= '0;
      r_cur_blk <= '0;
      r_rem     <= '0;
    end else begin
      r_pos     <= w_pos_nxt;
      r_cur_blk <= w_blk_nxt;
      r_rem     <= w_rem_nxt;
    end
  end

  // Block buffer: low row captured in RD1, high row in CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (r_state == S_RD1) begin
      r_buf[ROW_W-1:0] <= rdata;
    end else if (r_state == S_CAP) begin
      r_buf[BLK_W-1:ROW_W] <= rdata;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd         <= 1'b0;
      r_raddr      <= '0;
      r_coef       <= '0;
      r_coef_valid <= 1'b0;
      r_coef_last  <= 1'b0;
      r_blk_idx    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rd         <= w_rd_nxt;
      r_raddr      <= w_raddr_nxt;
      r_coef       <= w_coef_nxt;
      r_coef_valid <= w_valid_nxt;
      r_coef_last  <= w_last_nxt;
      r_blk_idx    <= w_blk_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

`ifdef TQ_RD_NZC_EN
  logic [4:0] w_nzc_cap;
  logic [4:0] r_nzc;

  // Non-zero count over the block as it is being completed in CAP.
  always_comb begin
    w_nzc_cap = '0;
    for (int k = 0; k < 16; k++) begin
      if (w_blk_src[k*COEF_W +: COEF_W] != '0) w_nzc_cap = w_nzc_cap + 5'd1;
    end
  end

  // Count is loaded on CAP->OUT and held for the whole block.
  always_ff @(posedge clk) begin
    if (rst)                   r_nzc <= '0;
    else if (r_state == S_CAP) r_nzc <= w_nzc_cap;
  end

  assign nzc_o = r_nzc;
`else
  assign nzc_o = '0;
`endif

  assign rd           = r_rd;
  assign raddr        = r_raddr;
  assign coef_o       = r_coef;
  assign coef_valid_o = r_coef_valid;
  assign coef_last_o  = r_coef_last;
  assign blk_idx_o    = r_blk_idx;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule

// File: tb/tb_tq_ram_rd_scan.sv
// tb_tq_ram_rd_scan: scoreboard bench for tq_ram_rd_scan with a behavioural
// registered-read RAM model.
module tb_tq_ram_rd_scan;

  typedef struct packed {
    logic [15:0] coef;
    logic        last;
    logic [3:0]  blk;
    logic [4:0]  nzc;
  } item_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [3:0]   blk_base_i = '0;
  logic [4:0]   blk_cnt_i = '0;
  logic         rd;
  logic [4:0]   raddr;
  logic [127:0] rdata = '0;
  logic [15:0]  coef_o;
  logic         coef_valid_o;
  logic         coef_ready_i = 1'b1;
  logic         coef_last_o;
  logic [3:0]   blk_idx_o;
  logic [4:0]   nzc_o;
  logic         busy_o;
  logic         done_o;

  tq_ram_rd_scan #(.COEF_W(16), .AW(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .blk_base_i(blk_base_i),
    .blk_cnt_i(blk_cnt_i), .rd(rd), .raddr(raddr), .rdata(rdata),
    .coef_o(coef_o), .coef_valid_o(coef_valid_o), .coef_ready_i(coef_ready_i),
    .coef_last_o(coef_last_o), .blk_idx_o(blk_idx_o), .nzc_o(nzc_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [0:31];
  always @(posedge clk) if (rd) rdata <= mem[raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int zz_tb [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  int    n_cmp = 0;
  int    n_bad = 0;
  item_t exp_q [$];
  item_t obs_q [$];
  int    rd_q [$];
  int    rd_cyc_q [$];
  int    done_cnt, done_cyc, valid_cnt, busy_cnt, stab_err, first_valid_cyc;
  int    t_start;
  logic  prev_v = 1'b0, prev_r = 1'b0;
  item_t prev_item = '0;

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin
    item_t cur;
    cur = {coef_o, coef_last_o, blk_idx_o, nzc_o};
    if (coef_valid_o) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (coef_valid_o && coef_ready_i) obs_q.push_back(cur);
    if (rd) begin rd_q.push_back(int'(raddr)); rd_cyc_q.push_back(cyc); end
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (busy_o) busy_cnt++;
    if (prev_v && !prev_r && (!coef_valid_o || cur != prev_item)) stab_err++;
    prev_v = coef_valid_o; prev_r = coef_ready_i; prev_item = cur;
  end

  // Reference model: expected stream of one block from the RAM image.
  task automatic push_block(input int b);
    logic [127:0] r;
    logic [15:0]  v [16];
    int           nz;
    nz = 0;
    for (int k = 0; k < 16; k++) begin
      r = mem[2*b + k/8];
      v[k] = r[16*(k%8) +: 16];
      if (v[k] != 16'd0) nz++;
    end
    for (int p = 0; p < 16; p++) begin
`ifdef TQ_RD_NZC_EN
      exp_q.push_back({v[zz_tb[p]], (p == 15), 4'(b), 5'(nz)});
`else
      exp_q.push_back({v[zz_tb[p]], (p == 15), 4'(b), 5'd0});
`endif
    end
  endtask

  task automatic do_start(input logic [3:0] b, input logic [4:0] c);
    @(posedge clk); #1;
    obs_q.delete(); rd_q.delete(); rd_cyc_q.delete();
    done_cnt = 0; valid_cnt = 0; busy_cnt = 0; stab_err = 0; first_valid_cyc = -1;
    start_i = 1'b1; blk_base_i = b; blk_cnt_i = c;
    @(posedge clk); #1;
    t_start = cyc;
    start_i = 1'b0; blk_base_i = 4'($urandom); blk_cnt_i = 5'($urandom);
  endtask

  // Drives ready (optionally 1,0,0,1 pattern) until done_o or budget; can inject
  // a stray start or a reset after a given number of handshakes.
  task automatic run_scan(input int budget, input bit bp, input int start_at,
                          input int rst_at, output bit to);
    int  n, k, hs;
    bit  inj;
    bit  pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = 0; k = 0; inj = 1'b0; to = 1'b1;
    while (n < budget) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      hs = obs_q.size();
      if (start_at >= 0 && hs == start_at && !inj) begin
        start_i = 1'b1; blk_base_i = 4'd0; blk_cnt_i = 5'd3; inj = 1'b1;
      end
      if (rst_at >= 0 && hs == rst_at) begin
        rst = 1'b1; coef_ready_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; coef_ready_i = 1'b1; to = 1'b0;
        return;
      end
      coef_ready_i = bp ? pat[k%4] : 1'b1;
      k++;
      @(negedge clk); #1;
      if (done_cnt != 0) begin to = 1'b0; break; end
      n++;
    end
    start_i = 1'b0; coef_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      n_cmp++;
      if (coef_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", ph, coef_valid_o); end
      n_cmp++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done[%0d]: got %b%b want 00", ph, busy_o, done_o); end
      n_cmp++;
      if (rd !== 1'b0) begin n_bad++; $display("FAIL reset_rd[%0d]: got %b want 0", ph, rd); end
      n_cmp++;
      if ({raddr, coef_o, coef_last_o, blk_idx_o, nzc_o} !== 31'd0) begin
        n_bad++; $display("FAIL reset_data[%0d]: got raddr=%0d coef=%0d last=%b blk=%0d nzc=%0d want all 0",
                          ph, raddr, coef_o, coef_last_o, blk_idx_o, nzc_o);
      end
      @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  task automatic test_single_block();
    int    seq [16] = '{1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16};
    logic [127:0] r0, r1;
    item_t e, o;
    bit    to;
    for (int k = 0; k < 8; k++) begin r0[16*k +: 16] = 16'(k + 1); r1[16*k +: 16] = 16'(k + 9); end
    mem[6] = r0; mem[7] = r1;
    for (int p = 0; p < 16; p++) begin
`ifdef TQ_RD_NZC_EN
      exp_q.push_back({16'(seq[p]), (p == 15), 4'd3, 5'd16});
`else
      exp_q.push_back({16'(seq[p]), (p == 15), 4'd3, 5'd0});
`endif
    end
    do_start(4'd3, 5'd1);
    run_scan(100, 1'b0, -1, -1, to);
    repeat (3) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL single_timeout: no done_o within budget"); end
    n_cmp++; if (obs_q.size() !== 16) begin n_bad++; $display("FAIL single_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL single_coef: got coef=%0d last=%b blk=%0d nzc=%0d want coef=%0d last=%b blk=%0d nzc=%0d",
                                          $signed(o.coef), o.last, o.blk, o.nzc, $signed(e.coef), e.last, e.blk, e.nzc); end
    end
    exp_q.delete();
    n_cmp++;
    if (rd_q.size() !== 2 || rd_q[0] !== 6 || rd_q[1] !== 7) begin
      n_bad++; $display("FAIL single_raddr: got %0d reads first=%0d want 6,7", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1);
    end
    n_cmp++;
    if (rd_cyc_q.size() !== 2 || rd_cyc_q[0] !== t_start || rd_cyc_q[1] !== t_start + 1) begin
      n_bad++; $display("FAIL single_rd_timing: got first rd at +%0d want +0,+1", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] - t_start : -1);
    end
    n_cmp++; if (first_valid_cyc !== t_start + 3) begin n_bad++; $display("FAIL single_first_valid: got +%0d want +3", first_valid_cyc - t_start); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== t_start + 19) begin n_bad++; $display("FAIL single_done_time: got +%0d want +19", done_cyc - t_start); end
    n_cmp++; if (busy_cnt !== 19) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 19", busy_cnt); end
  endtask

  task automatic test_backpressure();
    item_t e, o;
    bit    to;
    push_block(5);
    do_start(4'd5, 5'd1);
    run_scan(300, 1'b1, -1, -1, to);
    repeat (2) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: no done_o within budget"); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
    n_cmp++; if (obs_q.size() !== 16) begin n_bad++; $display("FAIL bp_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL bp_coef: got coef=%0d last=%b blk=%0d want coef=%0d last=%b blk=%0d",
                                          $signed(o.coef), o.last, o.blk, $signed(e.coef), e.last, e.blk); end
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    int    want_addr [4] = '{30, 31, 0, 1};
    item_t e, o;
    bit    to;
    push_block(15); push_block(0);
    do_start(4'd15, 5'd2);
    run_scan(200, 1'b0, -1, -1, to);
    repeat (2) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL wrap_timeout: no done_o within budget"); end
    n_cmp++; if (rd_q.size() !== 4) begin n_bad++; $display("FAIL wrap_rd_count: got %0d want 4", rd_q.size()); end
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      n_cmp++;
      if (rd_q[i] !== want_addr[i]) begin n_bad++; $display("FAIL wrap_raddr[%0d]: got %0d want %0d", i, rd_q[i], want_addr[i]); end
    end
    n_cmp++; if (obs_q.size() !== 32) begin n_bad++; $display("FAIL wrap_count: got %0d want 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL wrap_coef: got coef=%0d last=%b blk=%0d want coef=%0d last=%b blk=%0d",
                                          $signed(o.coef), o.last, o.blk, $signed(e.coef), e.last, e.blk); end
    end
    exp_q.delete();
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zero_cnt();
    bit to;
    do_start(4'd7, 5'd0);
    run_scan(20, 1'b0, -1, -1, to);
    repeat (4) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL zero_timeout: no done_o within budget"); end
    n_cmp++; if (done_cyc !== t_start) begin n_bad++; $display("FAIL zero_done_time: got +%0d want +0", done_cyc - t_start); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (rd_q.size() !== 0) begin n_bad++; $display("FAIL zero_rd: got %0d reads want 0", rd_q.size()); end
    n_cmp++; if (valid_cnt !== 0) begin n_bad++; $display("FAIL zero_valid: got %0d valid cycles want 0", valid_cnt); end
    n_cmp++; if (busy_cnt !== 0) begin n_bad++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt); end
  endtask

  task automatic test_start_ignored();
    item_t e, o;
    bit    to;
    push_block(2);
    do_start(4'd2, 5'd1);
    run_scan(100, 1'b0, 5, -1, to);
    repeat (6) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL ign_timeout: no done_o within budget"); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++;
    if (rd_q.size() !== 2 || rd_q[0] !== 4) begin
      n_bad++; $display("FAIL ign_raddr: got %0d reads first=%0d want 4,5", rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : -1);
    end
    n_cmp++; if (obs_q.size() !== 16) begin n_bad++; $display("FAIL ign_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ign_coef: got coef=%0d blk=%0d want coef=%0d blk=%0d",
                                          $signed(o.coef), o.blk, $signed(e.coef), e.blk); end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    item_t e, o;
    bit    to;
    do_start(4'd1, 5'd2);
    run_scan(100, 1'b0, -1, 7, to);
    @(negedge clk);
    n_cmp++; if (coef_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", coef_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    n_cmp++; if (obs_q.size() !== 7) begin n_bad++; $display("FAIL rstmid_hs: got %0d handshakes want 7", obs_q.size()); end
    push_block(4);
    do_start(4'd4, 5'd1);
    run_scan(100, 1'b0, -1, -1, to);
    repeat (2) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout: no done_o within budget"); end
    n_cmp++; if (obs_q.size() !== 16) begin n_bad++; $display("FAIL rstmid_count: got %0d want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rstmid_coef: got coef=%0d last=%b blk=%0d want coef=%0d last=%b blk=%0d",
                                          $signed(o.coef), o.last, o.blk, $signed(e.coef), e.last, e.blk); end
    end
    exp_q.delete();
  endtask

  task automatic test_nzc();
    logic [127:0] r;
    item_t e, o;
    bit    to;
    r = '0; r[32 +: 16] = 16'd3; r[64 +: 16] = 16'hFFFF;
    mem[18] = r; mem[19] = '0; mem[20] = '0; mem[21] = '0;
    push_block(9); push_block(10);
    do_start(4'd9, 5'd2);
    run_scan(200, 1'b1, -1, -1, to);
    repeat (2) @(negedge clk);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL nzc_timeout: no done_o within budget"); end
    n_cmp++; if (obs_q.size() !== 32) begin n_bad++; $display("FAIL nzc_count: got %0d want 32", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL nzc_item: got coef=%0d blk=%0d nzc=%0d want coef=%0d blk=%0d nzc=%0d",
                                          $signed(o.coef), o.blk, o.nzc, $signed(e.coef), e.blk, e.nzc); end
    end
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] r;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 8; k++) r[16*k +: 16] = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
      mem[i] = r;
    end
    test_reset();
    test_single_block();
    test_backpressure();
    test_wrap();
    test_zero_cnt();
    test_start_ignored();
    test_reset_mid();
    test_nzc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
